traffic_phase_controller: RTL and testbench
===========================================

// Module: traffic_phase_controller
// PURPOSE
//   Main/side junction phase sequencer. Consumes the registered vehicle_detected / ped_detected flags
//   from the sensor interface stage and drives the lamp and walk outputs. Main road rests on green.
//   Side-road vehicles and pedestrians are latched as requests and served after a minimum main green.
//   The request latches mean a one-cycle sensor pulse is never lost.
// PARAMETERS
//   MIN_GREEN   20  minimum MAIN_GREEN dwell (cycles) before a request may be served
//   YELLOW       4  MAIN_YELLOW / SIDE_YELLOW dwell (cycles)
//   ALL_RED      2  ALL_RED_A / ALL_RED_B dwell (cycles)
//   SIDE_GREEN  15  SIDE_GREEN dwell (cycles)
//   WALK        10  PED_WALK dwell (cycles)
//   CNT_W        8  phase timer width; must hold max(all durations)-1; every duration >= 1
// PORTS
//   clk               in   1  system clock, rising edge
//   reset             in   1  synchronous, active-high reset
//   vehicle_detected  in   1  side-road vehicle present (from sensor stage)
//   ped_detected      in   1  pedestrian button/presence (from sensor stage)
//   main_light        out  3  {red,yellow,green} main road, one-hot
//   side_light        out  3  {red,yellow,green} side road, one-hot
//   walk              out  1  pedestrian walk lamp
//   ped_pending       out  1  pedestrian request latched, not yet served
//   phase             out  3  current state encoding (debug/monitor)
// BEHAVIOUR
// - Reset (sync, at clk edge while reset=1, overrides all inputs that cycle):
//   - state=MAIN_GREEN(0), timer=0, side_req=0, ped_req=0.
//   - main_light=001, side_light=100, walk=0, ped_pending=0, phase=0.
// - States/encoding: MAIN_GREEN 0, MAIN_YELLOW 1, ALL_RED_A 2, PED_WALK 3, SIDE_GREEN 4, SIDE_YELLOW 5, ALL_RED_B 6.
//   7 is illegal; it recovers to MAIN_GREEN on next edge.
// - Outputs are Moore decode of the state register; they change on the same edge as state.
//   - MAIN_GREEN: main 001, side 100. MAIN_YELLOW: main 010, side 100.
//   - SIDE_GREEN: main 100, side 001. SIDE_YELLOW: main 100, side 010.
//   - ALL_RED_A/B, PED_WALK: main 100, side 100.
//   - walk=1 only in PED_WALK. Never any green on both roads.
// - Request latches (registered):
//   - side_req set on vehicle_detected=1 in any state except SIDE_GREEN; cleared on the edge entering SIDE_GREEN.
//   - ped_req set on ped_detected=1 in any state except PED_WALK; cleared on the edge entering PED_WALK.
//   - ped_pending=ped_req.
// - Timer: 0 on every state entry, +1 per cycle.
//   - Timed states leave on the edge where timer==DUR-1, so dwell = exactly DUR cycles.
//   - In MAIN_GREEN the timer saturates at MIN_GREEN-1.
// - Transitions:
//   - MAIN_GREEN -> MAIN_YELLOW when timer==MIN_GREEN-1 and (side_req|ped_req); otherwise hold indefinitely.
//   - MAIN_YELLOW -> ALL_RED_A after YELLOW cycles.
//   - ALL_RED_A -> PED_WALK if ped_req, else SIDE_GREEN. Pedestrian has priority.
//   - PED_WALK -> SIDE_GREEN if side_req, else ALL_RED_B.
//   - SIDE_GREEN -> SIDE_YELLOW after SIDE_GREEN cycles. SIDE_YELLOW -> ALL_RED_B after YELLOW cycles.
//   - ALL_RED_B -> MAIN_GREEN after ALL_RED cycles.
// - Latency: a request is first seen by the FSM one cycle after the detect input.
//   If min green has already elapsed, MAIN_YELLOW appears 2 edges after the detect cycle.
// - Simultaneous events:
//   - Vehicle and pedestrian together are served as PED_WALK then SIDE_GREEN in one cycle round.
//   - ped_detected during SIDE_GREEN/SIDE_YELLOW/ALL_RED_B is held and served in the next round, after full MIN_GREEN.
//   - vehicle_detected during SIDE_GREEN is ignored (already served).
// - Reset mid-phase: next edge returns to MAIN_GREEN with both requests cleared; no yellow/all-red sequence is inserted.
// TESTING (MIN_GREEN=5 YELLOW=2 ALL_RED=1 SIDE_GREEN=4 WALK=3; cycle 0 = first cycle after reset released)
// - Idle: no detects for 200 cycles -> main_light=001, side_light=100, walk=0, phase=0 throughout.
// - Vehicle pulse at cycle 0 -> MAIN_YELLOW cycles 5-6, ALL_RED_A 7, SIDE_GREEN 8-11 (side 001),
//   SIDE_YELLOW 12-13, ALL_RED_B 14, MAIN_GREEN 15. side_req low from cycle 8.
// - Vehicle+ped pulse at cycle 0 -> ALL_RED_A 7, PED_WALK 8-10 (walk=1), SIDE_GREEN 11-14,
//   MAIN_GREEN at 18. ped_pending 1->0 at 8.
// - Ped only at cycle 0 -> PED_WALK 8-10, ALL_RED_B 11, MAIN_GREEN 12. side_light=100 throughout.
// - Ped pulse during SIDE_GREEN (vehicle scenario, cycle 9) -> ped_pending stays 1.
//   MAIN_GREEN 15-19, MAIN_YELLOW 20, PED_WALK 23-25.
// - Reset pulse at cycle 9 (SIDE_GREEN) with ped pending -> cycle 10 shows phase=0, main 001,
//   ped_pending=0. Bench checks no overlapping greens via assertion in all tests.

Source files
------------

// File: rtl/traffic_phase_controller.sv
// rtl/traffic_phase_controller.sv - main/side junction phase sequencer with latched vehicle and pedestrian requests
// Main road rests on green; requests are served after a minimum main green, pedestrian first.
module traffic_phase_controller #(
  parameter int MIN_GREEN  = 20,
  parameter int YELLOW     = 4,
  parameter int ALL_RED    = 2,
  parameter int SIDE_GREEN = 15,
  parameter int WALK       = 10,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vehicle_detected,
  input  logic       ped_detected,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ST_MAIN_GREEN  = 3'd0,
    ST_MAIN_YELLOW = 3'd1,
    ST_ALL_RED_A   = 3'd2,
    ST_PED_WALK    = 3'd3,
    ST_SIDE_GREEN  = 3'd4,
    ST_SIDE_YELLOW = 3'd5,
    ST_ALL_RED_B   = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] MG_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] SG_LAST = CNT_W'(SIDE_GREEN - 1);
  localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(WALK - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             side_req_q, side_req_d;
  logic             ped_req_q, ped_req_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_MAIN_GREEN;
      timer_q    <= '0;
      side_req_q <= 1'b0;
      ped_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      side_req_q <= side_req_d;
      ped_req_q  <= ped_req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MAIN_GREEN:  if (timer_q == MG_LAST && (side_req_q || ped_req_q)) state_d = ST_MAIN_YELLOW;
      ST_MAIN_YELLOW: if (timer_q == Y_LAST) state_d = ST_ALL_RED_A;
      ST_ALL_RED_A:   if (timer_q == AR_LAST) state_d = ped_req_q ? ST_PED_WALK : ST_SIDE_GREEN;
      ST_PED_WALK:    if (timer_q == W_LAST) state_d = side_req_q ? ST_SIDE_GREEN : ST_ALL_RED_B;
      ST_SIDE_GREEN:  if (timer_q == SG_LAST) state_d = ST_SIDE_YELLOW;
      ST_SIDE_YELLOW: if (timer_q == Y_LAST) state_d = ST_ALL_RED_B;
      ST_ALL_RED_B:   if (timer_q == AR_LAST) state_d = ST_MAIN_GREEN;
      default:        state_d = ST_MAIN_GREEN;
    endcase

    // Main green parks its timer at the last count so a late request is served next edge.
    timer_d = timer_q + 1'b1;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q == ST_MAIN_GREEN && timer_q == MG_LAST) begin
      timer_d = timer_q;
    end

    side_req_d = side_req_q;
    if (state_d == ST_SIDE_GREEN && state_q != ST_SIDE_GREEN) begin
      side_req_d = 1'b0;
    end else if (vehicle_detected && state_q != ST_SIDE_GREEN) begin
      side_req_d = 1'b1;
    end

    ped_req_d = ped_req_q;
    if (state_d == ST_PED_WALK && state_q != ST_PED_WALK) begin
      ped_req_d = 1'b0;
    end else if (ped_detected && state_q != ST_PED_WALK) begin
      ped_req_d = 1'b1;
    end
  end

  always_comb begin
    main_light = 3'b100;
    side_light = 3'b100;
    case (state_q)
      ST_MAIN_GREEN:  main_light = 3'b001;
      ST_MAIN_YELLOW: main_light = 3'b010;
      ST_SIDE_GREEN:  side_light = 3'b001;
      ST_SIDE_YELLOW: side_light = 3'b010;
      default:        ;
    endcase
    walk        = (state_q == ST_PED_WALK);
    ped_pending = ped_req_q;
    phase       = state_q;
  end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb/tb_traffic_phase_controller.sv - scoreboard bench for traffic_phase_controller
// Stimulus queues hand-computed per-cycle phase/ped_pending; the monitor decodes lamps and compares.
module tb_traffic_phase_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vehicle_detected = 1'b0;
  logic       ped_detected = 1'b0;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  traffic_phase_controller #(
    .MIN_GREEN (5),
    .YELLOW    (2),
    .ALL_RED   (1),
    .SIDE_GREEN(4),
    .WALK      (3),
    .CNT_W     (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .vehicle_detected(vehicle_detected),
    .ped_detected    (ped_detected),
    .main_light      (main_light),
    .side_light      (side_light),
    .walk            (walk),
    .ped_pending     (ped_pending),
    .phase           (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] ph;
    logic       ped;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] ph_list[$];
  string      test_name = "none";
  bit         mon_active = 1'b0;
  int         checks = 0;
  int         failures = 0;

  function automatic logic [2:0] exp_main(input logic [2:0] ph);
    case (ph)
      3'd0:    return 3'b001;
      3'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_side(input logic [2:0] ph);
    case (ph)
      3'd4:    return 3'b001;
      3'd5:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic cmp(input string what, input int cyc, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s cyc=%0d actual=%b required=%b", test_name, what, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    checks++;
    assert (!(main_light[0] && side_light[0])) else begin
      failures++;
      $display("FAIL overlap_green t=%0t main=%b side=%b", $time, main_light, side_light);
    end
    if (mon_active) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s.underflow actual=empty required=entry", test_name);
      end else begin
        e = exp_q.pop_front();
        cmp("phase", e.cyc, phase, e.ph);
        cmp("main_light", e.cyc, main_light, exp_main(e.ph));
        cmp("side_light", e.cyc, side_light, exp_side(e.ph));
        cmp("walk", e.cyc, {2'b00, walk}, {2'b00, (e.ph == 3'd3)});
        cmp("ped_pending", e.cyc, {2'b00, ped_pending}, {2'b00, e.ped});
      end
    end
  end

  task automatic seg(input logic [2:0] ph, input int cnt);
    repeat (cnt) ph_list.push_back(ph);
  endtask

  // va/vb: vehicle pulse cycles, pa: ped pulse cycle, rc: reset pulse cycle (-1 = none);
  // ped_pending is expected high for ped_on <= cycle < ped_off.
  task automatic run(input string name, input int va, input int vb, input int pa, input int rc,
                     input int ped_on, input int ped_off);
    int n;
    exp_t e;
    reset = 1'b1;
    vehicle_detected = 1'b0;
    ped_detected = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_name = name;
    n = ph_list.size();
    for (int c = 0; c < n; c++) begin
      e.cyc = c;
      e.ph  = ph_list[c];
      e.ped = (c >= ped_on) && (c < ped_off);
      exp_q.push_back(e);
    end
    ph_list.delete();
    mon_active = 1'b1;
    for (int i = 0; i < n; i++) begin
      vehicle_detected = (i == va) || (i == vb);
      ped_detected     = (i == pa);
      reset            = (i == rc);
      @(posedge clk);
      #1;
    end
    mon_active = 1'b0;
    vehicle_detected = 1'b0;
    ped_detected = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    seg(0, 200);
    run("idle", -1, -1, -1, -1, 0, 0);

    seg(0, 5); seg(1, 2); seg(2, 1); seg(4, 4); seg(5, 2); seg(6, 1); seg(0, 10);
    run("vehicle", 0, 9, -1, -1, 0, 0);

    seg(0, 5); seg(1, 2); seg(2, 1); seg(3, 3); seg(4, 4); seg(5, 2); seg(6, 1); seg(0, 4);
    run("veh_ped", 0, -1, 0, -1, 1, 8);

    seg(0, 5); seg(1, 2); seg(2, 1); seg(3, 3); seg(6, 1); seg(0, 4);
    run("ped_only", -1, -1, 0, -1, 1, 8);

    seg(0, 5); seg(1, 2); seg(2, 1); seg(4, 4); seg(5, 2); seg(6, 1);
    seg(0, 5); seg(1, 2); seg(2, 1); seg(3, 3); seg(6, 1); seg(0, 3);
    run("ped_in_side", 0, -1, 9, -1, 10, 23);

    seg(0, 5); seg(1, 2); seg(2, 1); seg(4, 2); seg(0, 6);
    run("reset_mid", 0, -1, 8, 9, 9, 10);

    seg(0, 12); seg(1, 2); seg(2, 1); seg(4, 4); seg(5, 1);
    run("late_vehicle", 10, -1, -1, -1, 0, 0);

    seg(0, 5); seg(1, 2); seg(2, 1); seg(4, 1);
    run("veh_at_3", 3, -1, -1, -1, 0, 0);

    seg(0, 6); seg(1, 2); seg(2, 1);
    run("veh_at_4", 4, -1, -1, -1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
